// File: rtl/rr_shim.sv
// Static-side shim for one reconfigurable region: RM->static FIFO, static->RM
// passthrough, and the quiesce/drain/isolate/reset sequence around a module swap.
//
// state  | meaning
// RST_RM | RM held in reset for RST_CYC cycles
// RUN    | normal operation, both streams flowing
// REQ    | quiesce requested, waiting for ack or timeout
// DRAIN  | RM isolated, FIFO emptying towards static
// ISOL   | drained and isolated, safe to swap; wait for rc_done
module rr_shim #(
   parameter int DW          = 32,
   parameter int DEPTH       = 4,
   parameter int ACK_TIMEOUT = 255,
   parameter int RST_CYC     = 4
) (
   input  logic          clk,
   input  logic          rstn,
   input  logic          rc_start,
   input  logic          rc_done,
   output logic          rc_idle,
   output logic          rc_err,
   output logic          rm_rstn,
   output logic          rc_reqn,
   input  logic          rc_ackn,
   input  logic          rm_p_prdy,
   output logic          rm_p_crdy,
   output logic          rm_p_cerr,
   input  logic [DW-1:0] rm_p_data,
   output logic          st_p_prdy,
   input  logic          st_p_crdy,
   input  logic          st_p_cerr,
   output logic [DW-1:0] st_p_data,
   input  logic          st_c_prdy,
   output logic          st_c_crdy,
   output logic          st_c_cerr,
   input  logic [DW-1:0] st_c_data,
   output logic          rm_c_prdy,
   input  logic          rm_c_crdy,
   input  logic          rm_c_cerr,
   output logic [DW-1:0] rm_c_data
);

   localparam int AW      = $clog2(DEPTH);
   localparam int CNT_MAX = (ACK_TIMEOUT > RST_CYC) ? ACK_TIMEOUT : RST_CYC;
   localparam int CW      = $clog2(CNT_MAX + 1);

   typedef enum logic [2:0] {RST_RM, RUN, REQ, DRAIN, ISOL} state_t;

   state_t         state, state_nxt;
   logic [CW-1:0]  cnt, cnt_nxt;
   logic           err_q, err_nxt;

   logic [DW-1:0]  mem [DEPTH];
   logic [AW-1:0]  wptr, rptr;
   logic [AW:0]    fcount, fcount_nxt;
   logic           full, flow, push, pop;

   assign flow       = (state == RUN) || (state == REQ);
   assign full       = (fcount == (AW+1)'(DEPTH));
   assign push       = rm_p_prdy && rm_p_crdy;
   assign pop        = st_p_prdy && st_p_crdy;
   assign fcount_nxt = fcount + (AW+1)'(push) - (AW+1)'(pop);

   assign st_p_prdy  = (fcount != '0);
   assign st_p_data  = mem[rptr];
   assign rm_c_data  = st_c_data;
   assign rc_err     = err_q;

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      err_nxt   = err_q;
      rm_rstn   = 1'b1;
      rc_reqn   = 1'b1;
      rc_idle   = 1'b0;
      rm_p_crdy = 1'b0;
      rm_p_cerr = 1'b0;
      st_c_cerr = 1'b0;
      rm_c_prdy = 1'b0;
      st_c_crdy = 1'b0;
      if (flow) begin
         rm_p_crdy = !full;
         rm_p_cerr = st_p_cerr;
         st_c_cerr = rm_c_cerr;
         rm_c_prdy = st_c_prdy;
         st_c_crdy = rm_c_crdy;
      end
      case (state)
         RST_RM: begin
            rm_rstn = 1'b0;
            if (cnt <= CW'(1)) state_nxt = RUN;
            else               cnt_nxt   = cnt - CW'(1);
         end
         RUN: begin
            if (rc_start) begin
               state_nxt = REQ;
               err_nxt   = 1'b0;
               cnt_nxt   = CW'(ACK_TIMEOUT);
            end
         end
         REQ: begin
            rc_reqn = 1'b0;
            if (!rc_ackn) begin
               state_nxt = DRAIN;
            end else if (cnt <= CW'(1)) begin
               state_nxt = DRAIN;
               err_nxt   = 1'b1;
            end else begin
               cnt_nxt = cnt - CW'(1);
            end
         end
         DRAIN: begin
            rc_reqn = 1'b0;
            // look ahead so rc_idle rises right after the final pop
            if (fcount_nxt == '0) state_nxt = ISOL;
         end
         ISOL: begin
            rc_reqn = 1'b0;
            rc_idle = 1'b1;
            if (rc_done) begin
               state_nxt = RST_RM;
               cnt_nxt   = CW'(RST_CYC);
            end
         end
         default: begin
            state_nxt = RST_RM;
            cnt_nxt   = CW'(RST_CYC);
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         state  <= RST_RM;
         cnt    <= CW'(RST_CYC);
         err_q  <= 1'b0;
         wptr   <= '0;
         rptr   <= '0;
         fcount <= '0;
      end else begin
         state  <= state_nxt;
         cnt    <= cnt_nxt;
         err_q  <= err_nxt;
         fcount <= fcount_nxt;
         if (push) wptr <= wptr + AW'(1);
         if (pop)  rptr <= rptr + AW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem[wptr] <= rm_p_data;
   end

endmodule

// File: tb/tb_rr_shim.sv
// Directed bench for rr_shim: FIFO words scored through a queue checked by a
// separate monitor; sequencing outputs checked inline against hand values.
module tb_rr_shim;

   localparam int DW = 32;

   logic          clk = 1'b0;
   logic          rstn;
   logic          rc_start, rc_done, rc_idle, rc_err, rm_rstn, rc_reqn, rc_ackn;
   logic          rm_p_prdy, rm_p_crdy, rm_p_cerr;
   logic [DW-1:0] rm_p_data;
   logic          st_p_prdy, st_p_crdy, st_p_cerr;
   logic [DW-1:0] st_p_data;
   logic          st_c_prdy, st_c_crdy, st_c_cerr;
   logic [DW-1:0] st_c_data;
   logic          rm_c_prdy, rm_c_crdy, rm_c_cerr;
   logic [DW-1:0] rm_c_data;

   int checks   = 0;
   int failures = 0;
   logic [DW-1:0] exp_q [$];

   rr_shim #(.DW(DW), .DEPTH(4), .ACK_TIMEOUT(8), .RST_CYC(4)) dut (
      .clk(clk), .rstn(rstn),
      .rc_start(rc_start), .rc_done(rc_done), .rc_idle(rc_idle), .rc_err(rc_err),
      .rm_rstn(rm_rstn), .rc_reqn(rc_reqn), .rc_ackn(rc_ackn),
      .rm_p_prdy(rm_p_prdy), .rm_p_crdy(rm_p_crdy), .rm_p_cerr(rm_p_cerr),
      .rm_p_data(rm_p_data),
      .st_p_prdy(st_p_prdy), .st_p_crdy(st_p_crdy), .st_p_cerr(st_p_cerr),
      .st_p_data(st_p_data),
      .st_c_prdy(st_c_prdy), .st_c_crdy(st_c_crdy), .st_c_cerr(st_c_cerr),
      .st_c_data(st_c_data),
      .rm_c_prdy(rm_c_prdy), .rm_c_crdy(rm_c_crdy), .rm_c_cerr(rm_c_cerr),
      .rm_c_data(rm_c_data)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic push_word(input logic [DW-1:0] d);
      rm_p_prdy = 1'b1;
      rm_p_data = d;
      chk("push_crdy", rm_p_crdy, 1);
      exp_q.push_back(d);
      step();
      rm_p_prdy = 1'b0;
   endtask

   // scoreboard monitor: every static-side pop must match the next queued word
   always @(negedge clk) begin
      if (rstn && st_p_prdy && st_p_crdy) begin
         checks++;
         if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL fifo_out: got %h expected no word", st_p_data);
         end else begin
            logic [DW-1:0] e;
            e = exp_q.pop_front();
            if (st_p_data !== e) begin
               failures++;
               $display("FAIL fifo_out: got %h expected %h", st_p_data, e);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
      $fatal(1, "watchdog");
   end

   initial begin
      rstn = 1'b0; rc_start = 1'b0; rc_done = 1'b0; rc_ackn = 1'b1;
      rm_p_prdy = 1'b0; rm_p_data = '0; st_p_crdy = 1'b0; st_p_cerr = 1'b0;
      st_c_prdy = 1'b0; st_c_data = '0; rm_c_crdy = 1'b0; rm_c_cerr = 1'b0;

      // reset and RM reset window
      step(); step();
      chk("rst_rm_rstn", rm_rstn, 0);
      chk("rst_reqn", rc_reqn, 1);
      chk("rst_idle", rc_idle, 0);
      chk("rst_st_p_prdy", st_p_prdy, 0);
      chk("rst_rm_p_crdy", rm_p_crdy, 0);
      chk("rst_st_c_crdy", st_c_crdy, 0);
      chk("rst_err", rc_err, 0);
      rstn = 1'b1;
      for (int i = 0; i < 4; i++) begin
         chk("rstwin_rm_rstn", rm_rstn, 0);
         chk("rstwin_st_p_prdy", st_p_prdy, 0);
         step();
      end
      chk("run_rm_rstn", rm_rstn, 1);
      chk("run_reqn", rc_reqn, 1);

      // fill to full with consumer stalled, then drain in order
      push_word(32'h11); push_word(32'h22); push_word(32'h33); push_word(32'h44);
      chk("full_crdy", rm_p_crdy, 0);
      st_p_crdy = 1'b1;
      for (int i = 0; i < 4; i++) begin
         chk("drain_prdy", st_p_prdy, 1);
         step();
      end
      chk("empty_prdy", st_p_prdy, 0);
      chk("queue_empty", exp_q.size(), 0);

      // back-to-back push with pop
      push_word(32'hA1); push_word(32'hA2); push_word(32'hA3);
      step();
      chk("pp_empty", st_p_prdy, 0);

      // reconfig with ack after two REQ cycles
      st_p_crdy = 1'b0;
      push_word(32'h01); push_word(32'h02); push_word(32'h03);
      rc_start = 1'b1; step(); rc_start = 1'b0;
      chk("req_reqn", rc_reqn, 0);
      chk("req_crdy", rm_p_crdy, 1);
      step();
      rc_ackn = 1'b0; step(); rc_ackn = 1'b1;
      st_c_prdy = 1'b1; rm_c_crdy = 1'b1; st_p_cerr = 1'b1; rm_c_cerr = 1'b1;
      #1;
      chk("drain_rm_p_crdy", rm_p_crdy, 0);
      chk("drain_st_c_crdy", st_c_crdy, 0);
      chk("drain_rm_c_prdy", rm_c_prdy, 0);
      chk("drain_rm_p_cerr", rm_p_cerr, 0);
      chk("drain_st_c_cerr", st_c_cerr, 0);
      rc_start = 1'b1;
      st_p_crdy = 1'b1;
      for (int i = 0; i < 3; i++) begin
         chk("drain_idle", rc_idle, 0);
         chk("drain_reqn", rc_reqn, 0);
         step();
         rc_start = 1'b0;
      end
      chk("isol_idle", rc_idle, 1);
      chk("isol_err", rc_err, 0);
      chk("isol_prdy", st_p_prdy, 0);

      // ISOL ignores RM side
      rm_p_prdy = 1'b1; rm_p_data = 32'hDEAD; rc_ackn = 1'b0;
      step(); step();
      chk("isol_rm_p_crdy", rm_p_crdy, 0);
      chk("isol_st_c_crdy", st_c_crdy, 0);
      chk("isol_st_c_cerr", st_c_cerr, 0);
      chk("isol_no_write", st_p_prdy, 0);
      chk("isol_idle2", rc_idle, 1);
      rm_p_prdy = 1'b0; rc_ackn = 1'b1; st_c_prdy = 1'b0; rm_c_crdy = 1'b0;
      st_p_cerr = 1'b0; rm_c_cerr = 1'b0;
      rc_done = 1'b1; step(); rc_done = 1'b0;
      for (int i = 0; i < 4; i++) begin
         chk("swap_rm_rstn", rm_rstn, 0);
         chk("swap_idle", rc_idle, 0);
         step();
      end
      chk("swap_run_rstn", rm_rstn, 1);
      chk("swap_run_reqn", rc_reqn, 1);

      // passthrough and cerr forwarding in RUN
      st_c_prdy = 1'b1; st_c_data = 32'hCAFE0001; rm_c_crdy = 1'b1;
      rm_c_cerr = 1'b1; st_p_cerr = 1'b1;
      #1;
      chk("pt_rm_c_prdy", rm_c_prdy, 1);
      chk("pt_rm_c_data", rm_c_data, 32'hCAFE0001);
      chk("pt_st_c_crdy", st_c_crdy, 1);
      chk("pt_st_c_cerr", st_c_cerr, 1);
      chk("pt_rm_p_cerr", rm_p_cerr, 1);
      st_c_prdy = 1'b0; rm_c_crdy = 1'b0; rm_c_cerr = 1'b0; st_p_cerr = 1'b0;

      // rc_done in RUN ignored
      rc_done = 1'b1; step(); rc_done = 1'b0;
      chk("done_run_rstn", rm_rstn, 1);
      chk("done_run_reqn", rc_reqn, 1);

      // ack timeout
      rc_start = 1'b1; step(); rc_start = 1'b0;
      for (int i = 0; i < 8; i++) begin
         chk("to_err_low", rc_err, 0);
         chk("to_reqn", rc_reqn, 0);
         step();
      end
      chk("to_err_set", rc_err, 1);
      chk("to_drain_idle", rc_idle, 0);
      step();
      chk("to_isol_idle", rc_idle, 1);
      rc_done = 1'b1; step(); rc_done = 1'b0;
      for (int i = 0; i < 4; i++) step();
      chk("to_run_rstn", rm_rstn, 1);
      chk("to_err_sticky", rc_err, 1);
      rc_start = 1'b1; step(); rc_start = 1'b0;
      chk("to_err_clear", rc_err, 0);

      // reset mid-reconfiguration discards FIFO
      st_p_crdy = 1'b0;
      push_word(32'h77);
      chk("mid_prdy", st_p_prdy, 1);
      rstn = 1'b0; step(); rstn = 1'b1;
      exp_q.delete();
      chk("mid_rst_prdy", st_p_prdy, 0);
      chk("mid_rst_rstn", rm_rstn, 0);
      chk("mid_rst_reqn", rc_reqn, 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
